// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment driver: sequential double-dabble binary->BCD
// conversion, then one digit per rising edge of divided_clk (sampled as data in clk domain).
module seg7_scan_driver #(
  parameter int unsigned WIDTH         = 14,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             divided_clk,
  input  logic [WIDTH-1:0] value,
  input  logic             load,
  output logic             busy,
  output logic [3:0]       an,
  output logic [6:0]       seg,
  output logic             dp
);

  localparam int unsigned CW   = $clog2(WIDTH + 1);
  localparam logic [31:0] MAXV = 32'd9999;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]      r_bin, w_bin_nxt, w_sat;
  logic [15:0]           r_bcd, w_bcd_nxt, w_bcd_adj;
  logic [15:0]           r_disp, w_disp_nxt;
  logic [16+WIDTH-1:0]   w_cat;
  logic                  r_div_q, w_step;
  logic [1:0]            r_idx, w_idx_nxt;
  logic                  r_live, w_live_nxt;
  logic [3:0]            r_an, w_an_nxt;
  logic [6:0]            r_seg, w_seg_nxt;
  logic [3:0]            w_digit, w_nz;
  logic                  w_blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  always_comb begin
    w_sat = (32'(value) > MAXV) ? WIDTH'(MAXV) : value;
    w_bcd_adj = r_bcd;
    for (int unsigned k = 0; k < 4; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
    w_cat = {w_bcd_adj, r_bin} << 1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bin_nxt   = r_bin;
    w_bcd_nxt   = r_bcd;
    w_disp_nxt  = r_disp;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_bin_nxt   = w_sat;
          w_bcd_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_bcd_nxt = w_cat[16+WIDTH-1 -: 16];
        w_bin_nxt = w_cat[WIDTH-1:0];
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        w_disp_nxt  = r_bcd;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Decode from next-cycle idx/disp so a COMMIT coinciding with a step shows the new value.
  always_comb begin
    w_step     = divided_clk & ~r_div_q;
    w_idx_nxt  = w_step ? r_idx + 2'd1 : r_idx;
    w_live_nxt = r_live | w_step;
    w_digit    = w_disp_nxt[{w_idx_nxt, 2'b00} +: 4];
    for (int unsigned k = 0; k < 4; k++) begin
      w_nz[k] = |w_disp_nxt[4*k +: 4];
    end
    w_blank   = BLANK_LEADING && (w_idx_nxt != 2'd0) && ~|(w_nz >> w_idx_nxt);
    w_an_nxt  = 4'b1111;
    w_seg_nxt = 7'h7F;
    if (w_live_nxt && !w_blank) begin
      w_an_nxt  = ~(4'b0001 << w_idx_nxt);
      w_seg_nxt = decode(w_digit);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_disp  <= '0;
      r_div_q <= 1'b0;
      r_idx   <= 2'd3;
      r_live  <= 1'b0;
      r_an    <= '1;
      r_seg   <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bin   <= w_bin_nxt;
      r_bcd   <= w_bcd_nxt;
      r_disp  <= w_disp_nxt;
      r_div_q <= divided_clk;
      r_idx   <= w_idx_nxt;
      r_live  <= w_live_nxt;
      r_an    <= w_an_nxt;
      r_seg   <= w_seg_nxt;
    end
  end

  assign busy = (r_state != S_IDLE);
  assign an   = r_an;
  assign seg  = r_seg;
  assign dp   = 1'b1;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Drives the four-digit, common-anode seven-segment display on the board. It captures a binary value, such as the Game of Life generation count, and converts it to BCD with a sequential double-dabble. It then time-multiplexes the four digits, stepping one digit on each rising edge of the 10 kHz `divided_clk` from the 7-seg clock divider, which is the stage directly upstream. Everything runs in the 100 MHz `clk` domain. `divided_clk` is used as a data input, never as a clock.

## Interface
- `WIDTH`, default 14: width of `value`. Its maximum, 16383, exceeds 9999, so saturation applies.
- `BLANK_LEADING`, default 1: when 1, leading-zero digits are switched off. Digit 0 is always lit.

- `clk`  in  1  100 MHz system clock; all flops on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `divided_clk`  in  1  10 kHz square wave from the clock divider. It is generated in the `clk` domain, so no synchronizer is needed.
- `value`  in  WIDTH  binary value to display.
- `load`  in  1  one-cycle pulse; captures `value` when `busy`=0.
- `busy`  out  1  high while a conversion runs.
- `an`  out  4  anode enables, active-low; bit 0 is the rightmost digit.
- `seg`  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low; tied to 1 (off).

## Operation
- **Edge detect.** `div_q` registers `divided_clk`. A scan step occurs in a cycle where `divided_clk`=1 and `div_q`=0. A level held high gives no further steps.
- **Conversion FSM.** States are IDLE, SHIFT and COMMIT.
  - IDLE: on `load`=1, capture min(`value`, 9999), clear the 16-bit BCD shift register, set the shift count to 0, and go to SHIFT.
  - SHIFT: runs exactly WIDTH cycles. In each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1.
  - COMMIT: copies the BCD result into the display register `disp[15:0]` and returns to IDLE.
  - `busy` is 1 in SHIFT and COMMIT.
  - `load` is ignored while `busy`=1. There is no queueing.
- **Scan.**
  - The 2-bit `idx` increments on each scan step and wraps 3→0.
  - The selected digit is `disp[4*idx+3 -: 4]`.
  - `an` = ~(4'b0001 << idx).
  - When `BLANK_LEADING`=1, digit k (k≥1) is blanked if it and all higher digits are 0. A blanked digit drives `an`=4'b1111 and `seg`=7'h7F.
- **Decode** to `seg` (hex, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10. Nibbles above 9 cannot occur; drive 7'h7F if one does.
- **Frame timing.** Each digit is lit for 100 µs, so the full frame is 400 µs (2.5 kHz refresh).

## Timing
- **Reset values:**
  - `an`=4'b1111, `seg`=7'h7F, `dp`=1, `busy`=0.
  - FSM=IDLE, `disp`=16'h0000, `idx`=2'd3, `div_q`=0.
  - The outputs stay blank until the first scan step. That step moves `idx` to 0.
- **Output registration.** `an` and `seg` are registered and change in the cycle after the scan-step cycle, i.e. one `clk` after `divided_clk` is seen high.
- **Conversion latency.**
  - `load` sampled at edge N gives `busy`=1 from edge N+1.
  - SHIFT occupies edges N+1 through N+WIDTH. COMMIT is at N+WIDTH+1, when `disp` updates.
  - `busy`=0 from edge N+WIDTH+2. With WIDTH=14, `load` to `busy` low is 16 cycles.
  - A new `load` is accepted in the cycle `busy` reads 0.
- **COMMIT coinciding with a scan step.** Both take effect together. The new digit is decoded from the new `disp`.
- **Display update between steps.** When `disp` changes between scan steps, the lit digit's `seg` updates on the next clock. Leaving the value visible mid-digit is intended.
- **Reset mid-conversion.** The conversion is aborted, `disp`=0 and all reset values apply. A `load` asserted in the same cycle as `reset` is dropped.

## Test plan
1. **Reset and first step.** Assert `reset` for 2 cycles → `an`=1111, `seg`=7F, `busy`=0. On the first `divided_clk` rise → `an`=1110, `seg`=40 one cycle later. The next three steps are blanked (`an`=1111).
2. **Load 1234.** Pulse `load` with `value`=1234 → `busy` is high for exactly 15 cycles, starting one cycle after `load`. Then four scan steps give `an`/`seg` = 1110/19, 1101/30, 1011/24, 0111/79, and step five returns to 1110/19.
3. **Saturation.** `value`=9999 and, separately, `value`=16383 → each shows four digits of `seg`=10.
4. **Blanking.**
   - `value`=7 → digit 0 shows `seg`=78; digits 1–3 give `an`=1111.
   - `value`=1000 → all four digits lit: 40, 40, 40, 79.
   - With `BLANK_LEADING`=0, `value`=7 shows 40 on digits 1–3.
5. **Load during busy and reset mid-conversion.**
   - Load 42, then pulse `load`=1 with `value`=99 four cycles later → the display shows 42.
   - Load 5678, then assert `reset` on the 5th `busy` cycle → `disp`=0 and `busy`=0 next cycle. After the first scan step the display shows 0.
6. **Edge-only scanning.** Hold `divided_clk` high for 10,000 cycles → `idx` and `an` do not change. The following 0→1 transition advances exactly one digit.
